// File: rtl/store_merge_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_merge_if : store-request handshake plus word-only memory bus |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface store_merge_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        done;
  logic        fault;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_readdata, mem_waitrequest,
    output req_ready, done, fault, mem_address, mem_read, mem_write, mem_writedata
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_readdata, mem_waitrequest,
    input  req_ready, done, fault, mem_address, mem_read, mem_write, mem_writedata
  );
endinterface
`default_nettype wire

// File: rtl/store_merge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_merge : byte/half stores into a word-only memory via RMW     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module store_merge (
  input  logic         clk,
  input  logic         reset,
  store_merge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FLT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_addr;
  logic [15:0] r_data;
  logic        r_half;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        w_accept;
  logic        w_word_ok;
  logic        w_narrow_ok;
  logic [31:0] w_merged;

  assign w_accept    = (r_state == IDLE) && bus.req_valid;
  assign w_word_ok   = (bus.req_size == 2'b10) && (bus.req_addr[1:0] == 2'b00);
  assign w_narrow_ok = (bus.req_size == 2'b00) ||
                       ((bus.req_size == 2'b01) && !bus.req_addr[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    bus.req_ready     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.fault         = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_word_ok)        w_state_next = WR;
          else if (w_narrow_ok) w_state_next = RD;
          else                  w_state_next = FLT;
        end
      end
      RD: begin
        bus.mem_read = 1'b1;
        if (!bus.mem_waitrequest) w_state_next = WR;
      end
      WR: begin
        bus.mem_write = 1'b1;
        if (!bus.mem_waitrequest) w_state_next = IDLE;
      end
      FLT: begin
        bus.fault    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Only byte/half requests reach RD, so size[0] alone selects the lane width.
  always_comb begin
    w_merged = bus.mem_readdata;
    case ({r_half, r_addr[1:0]})
      3'b000:         w_merged[7:0]   = r_data[7:0];
      3'b001:         w_merged[15:8]  = r_data[7:0];
      3'b010:         w_merged[23:16] = r_data[7:0];
      3'b011:         w_merged[31:24] = r_data[7:0];
      3'b100, 3'b101: w_merged[15:0]  = r_data;
      3'b110, 3'b111: w_merged[31:16] = r_data;
      default:        w_merged        = bus.mem_readdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= 32'd0;
      r_data  <= 16'd0;
      r_half  <= 1'b0;
      r_wdata <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == WR) && !bus.mem_waitrequest;
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_data  <= bus.req_data[15:0];
        r_half  <= bus.req_size[0];
        r_wdata <= bus.req_data;
      end else if ((r_state == RD) && !bus.mem_waitrequest) begin
        r_wdata <= w_merged;
      end
    end
  end

  assign bus.done          = r_done;
  assign bus.mem_address   = {r_addr[31:2], 2'b00};
  assign bus.mem_writedata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_store_merge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_store_merge : directed and randomized bench for store_merge     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_store_merge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_merge_if bus();
  store_merge dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int passes = 0;

  // Expected bus events for the single outstanding request.
  localparam int K_NONE = 0, K_FAULT = 1, K_READ = 2, K_WRITE = 3, K_DONE = 4;
  int          exp_kind;
  bit          post_reset;
  bit          was_ready;
  logic [31:0] m_addr, m_data, exp_wdata;
  logic [1:0]  m_size;
  int          n_reads, n_writes;
  logic [31:0] last_wr_addr, last_wr_data, last_rd_addr;

  // Stimulus-side controls for the memory responder.
  bit          rand_wait;
  int          wait_left;
  logic [31:0] rd_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                        input logic [31:0] d, input logic [1:0] s);
    logic [31:0] mask;
    int          sh;
    sh   = 8 * int'(off);
    mask = ((s == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic bit is_illegal(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  initial begin
    exp_kind   = K_NONE;
    post_reset = 1'b0;
    n_reads    = 0;
    n_writes   = 0;
    forever begin
      @(negedge clk);
      if (post_reset) begin
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_addr", bus.mem_address, 32'd0);
        chk("rst_wdata", bus.mem_writedata, 32'd0);
      end
      if (reset) begin
        exp_kind   = K_NONE;
        post_reset = 1'b1;
      end else begin
        post_reset = 1'b0;
        was_ready  = (exp_kind == K_NONE) || (exp_kind == K_DONE);
        chk("req_ready", 32'(bus.req_ready), 32'(was_ready));
        chk("done", 32'(bus.done), 32'(exp_kind == K_DONE));
        chk("fault", 32'(bus.fault), 32'(exp_kind == K_FAULT));
        chk("mem_read", 32'(bus.mem_read), 32'(exp_kind == K_READ));
        chk("mem_write", 32'(bus.mem_write), 32'(exp_kind == K_WRITE));
        case (exp_kind)
          K_READ: begin
            chk("rd_addr", bus.mem_address, {m_addr[31:2], 2'b00});
            if (!bus.mem_waitrequest) begin
              n_reads++;
              last_rd_addr = bus.mem_address;
              exp_wdata    = merge(bus.mem_readdata, m_addr[1:0], m_data, m_size);
              exp_kind     = K_WRITE;
            end
          end
          K_WRITE: begin
            chk("wr_addr", bus.mem_address, {m_addr[31:2], 2'b00});
            chk("wr_data", bus.mem_writedata, exp_wdata);
            if (!bus.mem_waitrequest) begin
              n_writes++;
              last_wr_addr = bus.mem_address;
              last_wr_data = bus.mem_writedata;
              exp_kind     = K_DONE;
            end
          end
          K_FAULT, K_DONE: exp_kind = K_NONE;
          default: ;
        endcase
        if (was_ready && bus.req_valid) begin
          m_addr = bus.req_addr;
          m_data = bus.req_data;
          m_size = bus.req_size;
          if (is_illegal(m_addr, m_size)) exp_kind = K_FAULT;
          else if (m_size == 2'b10) begin
            exp_kind  = K_WRITE;
            exp_wdata = m_data;
          end else exp_kind = K_READ;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.mem_read || bus.mem_write) begin
      if (wait_left > 0) begin
        bus.mem_waitrequest = 1'b1;
        wait_left--;
      end else if (rand_wait) bus.mem_waitrequest = ($urandom_range(0, 3) == 0);
      else bus.mem_waitrequest = 1'b0;
    end else begin
      bus.mem_waitrequest = ($urandom_range(0, 1) == 1);
    end
    bus.mem_readdata = (bus.mem_waitrequest || rand_wait) ? $urandom : rd_word;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int guard;
    bit acc;
    guard         = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
    do begin
      acc = bus.req_ready;
      tick();
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      checks++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, required 1", guard);
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_data  = $urandom;
    bus.req_size  = 2'($urandom);
  endtask

  task automatic wait_end(input int max, output int cyc);
    cyc = 1;
    while (!(bus.done || bus.fault) && cyc < max) begin
      tick();
      cyc++;
    end
    if (!(bus.done || bus.fault)) begin
      checks++;
      $display("FAIL end_timeout: no done/fault within %0d cycles, required one", max);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          nr;
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] bad_addr [3];
    logic [1:0]  bad_size [3];

    reset               = 1'b1;
    rand_wait           = 1'b0;
    wait_left           = 0;
    rd_word             = 32'd0;
    bus.req_valid       = 1'b0;
    bus.req_addr        = 32'd0;
    bus.req_data        = 32'd0;
    bus.req_size        = 2'b00;
    bus.mem_readdata    = 32'd0;
    bus.mem_waitrequest = 1'b0;

    repeat (3) tick();
    chk("init_read", 32'(bus.mem_read), 32'd0);
    chk("init_write", 32'(bus.mem_write), 32'd0);
    chk("init_addr", bus.mem_address, 32'd0);
    chk("init_wdata", bus.mem_writedata, 32'd0);
    reset = 1'b0;
    tick();
    chk("init_ready", 32'(bus.req_ready), 32'd1);

    // Word store: straight to write, no read.
    nr = n_reads;
    issue(32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
    chk("word_write_c1", 32'(bus.mem_write), 32'd1);
    chk("word_addr", bus.mem_address, 32'h0000_0100);
    chk("word_data", bus.mem_writedata, 32'hDEAD_BEEF);
    wait_end(20, cyc);
    chk("word_done_cycle", 32'(cyc), 32'd2);
    chk("word_no_read", 32'(n_reads - nr), 32'd0);
    tick();

    // Byte store into lane 3.
    rd_word = 32'h1122_3344;
    issue(32'h0000_0203, 32'h1234_56AB, 2'b00);
    chk("byte_read_c1", 32'(bus.mem_read), 32'd1);
    chk("byte_rd_addr", bus.mem_address, 32'h0000_0200);
    wait_end(20, cyc);
    chk("byte_done_cycle", 32'(cyc), 32'd3);
    chk("byte_wr_addr", last_wr_addr, 32'h0000_0200);
    chk("byte_wr_data", last_wr_data, 32'hAB22_3344);
    tick();

    // Upper half store with two read stalls.
    rd_word   = 32'hAAAA_BBBB;
    wait_left = 2;
    issue(32'h0000_0302, 32'hFFFF_BEEF, 2'b01);
    wait_end(20, cyc);
    chk("half_done_cycle", 32'(cyc), 32'd5);
    chk("half_rd_addr", last_rd_addr, 32'h0000_0300);
    chk("half_wr_data", last_wr_data, 32'hBEEF_BBBB);
    tick();

    // Rejected requests.
    bad_addr[0] = 32'h0000_0401; bad_size[0] = 2'b01;
    bad_addr[1] = 32'h0000_0402; bad_size[1] = 2'b10;
    bad_addr[2] = 32'h0000_0400; bad_size[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      issue(bad_addr[i], 32'h5555_5555, bad_size[i]);
      chk("flt_fault_c1", 32'(bus.fault), 32'd1);
      chk("flt_no_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
      tick();
      chk("flt_ready_c2", 32'(bus.req_ready), 32'd1);
    end

    // Reset while a write is stalled.
    wait_left = 10;
    issue(32'h0000_0700, 32'h0F0F_0F0F, 2'b10);
    chk("rstwr_write", 32'(bus.mem_write), 32'd1);
    reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0800;
    bus.req_size  = 2'b10;
    tick();
    chk("rstwr_no_write", 32'(bus.mem_write), 32'd0);
    chk("rstwr_no_done", 32'(bus.done), 32'd0);
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    wait_left     = 0;
    tick();
    chk("rstwr_ready", 32'(bus.req_ready), 32'd1);
    chk("rstwr_no_done2", 32'(bus.done), 32'd0);

    // Back-to-back: next request presented in the done cycle.
    rd_word = 32'h0000_0000;
    issue(32'h0000_0504, 32'h0000_00CD, 2'b00);
    wait_end(20, cyc);
    chk("b2b_ready_at_done", 32'(bus.req_ready), 32'd1);
    issue(32'h0000_0600, 32'h0BAD_F00D, 2'b10);
    chk("b2b_first_strobe", 32'(bus.mem_write), 32'd1);
    wait_end(20, cyc);
    chk("b2b_wr_data", last_wr_data, 32'h0BAD_F00D);
    tick();

    // Randomized traffic with random stalls, gaps and occasional resets.
    rand_wait = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int r;
      a = $urandom;
      r = $urandom_range(0, 9);
      s = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b01) a[0] = 1'b0;
        if (s == 2'b10) a[1:0] = 2'b00;
      end
      issue(a, $urandom, s);
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(0, 2)) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
      end else begin
        wait_end(60, cyc);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    rand_wait = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
